// File: rtl/imem_fetch_sequencer.sv
// Instruction-memory port owner: boot-loads the image, then fetches one word per unstalled cycle.
// Fetch latency 1 cycle (imem_addr -> instr_out); stall holds all fetch state, loader is always ready in BOOT.
module imem_fetch_sequencer #(
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned AW           = 7,
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          load_done,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          reload,
  output logic [31:0]   imem_addr,
  output logic          imem_we,
  output logic [31:0]   imem_wdata,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   instr_out,
  output logic [31:0]   pc_out,
  output logic          instr_valid,
  output logic          halted,
  output logic          fault,
  output logic [AW:0]   load_count
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [31:0] PC_LIM  = 32'(DEPTH);
  localparam logic [31:0] PC_LAST = 32'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_out_q, pc_out_d;
  logic          vld_q, vld_d;
  logic          fault_q, fault_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= 32'd0;
      pc_out_q <= 32'd0;
      vld_q    <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      vld_q    <= vld_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    vld_d    = vld_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_BOOT: begin
        vld_d = 1'b0;
        if (load_valid && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
        if (load_done) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (branch_taken) begin
          vld_d = 1'b0;
          if (branch_target >= PC_LIM) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = branch_target;
          end
        end else if (stall) begin
          vld_d = vld_q;
        end else if (HALT_ON_ZERO && (imem_rdata == 32'd0)) begin
          state_d = ST_HALT;
          vld_d   = 1'b0;
        end else begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          vld_d    = 1'b1;
          // Last word is still delivered; the sequencer parks instead of wrapping to 0.
          if (pc_q == PC_LAST) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_q + 32'd1;
          end
        end
      end
      ST_HALT: begin
        vld_d = 1'b0;
        if (reload) begin
          state_d = ST_BOOT;
          cnt_d   = '0;
          fault_d = 1'b0;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    if (state_q == ST_BOOT) begin
      imem_addr  = {{(32-AW){1'b0}}, load_addr};
      imem_we    = load_valid;
      imem_wdata = load_data;
    end else begin
      imem_addr  = pc_q;
      imem_we    = 1'b0;
      imem_wdata = 32'd0;
    end
  end

  assign load_ready  = (state_q == ST_BOOT);
  assign halted      = (state_q == ST_HALT);
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = vld_q;
  assign fault       = fault_q;
  assign load_count  = cnt_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer with a behavioural 128-word instruction memory.
module tb_imem_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [6:0]  load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        reload;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        halted;
  logic        fault;
  logic [7:0]  load_count;

  logic [31:0] mem [128] = '{default: 32'd0};
  logic [31:0] img [4]   = '{32'hA00000AA, 32'h10000011, 32'h20000022, 32'h30000033};

  int n_checks = 0;
  int n_errors = 0;

  imem_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .reload(reload),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .halted(halted), .fault(fault), .load_count(load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (imem_we) mem[imem_addr[6:0]] <= imem_wdata;
  assign imem_rdata = mem[imem_addr[6:0]];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [6:0] a, input logic [31:0] d, input logic done);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_done  = done;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  initial begin
    int ndeliv;
    int nbad;
    bit done;

    rst_n = 1'b0; load_valid = 1'b0; load_addr = 7'd5; load_data = 32'd0; load_done = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; reload = 1'b0;
    #2;
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("boot_addr_mux", imem_addr, 32'd5);
    chk("boot_we_idle", 32'(imem_we), 32'd0);
    tick();
    rst_n = 1'b1;

    // Image 0..3, load_done on the same cycle as the last write.
    for (int i = 0; i < 4; i++) write_word(7'(i), img[i], i == 3);
    chk("load_count4", 32'(load_count), 32'd4);
    chk("run_ready", 32'(load_ready), 32'd0);
    chk("run_first_valid", 32'(instr_valid), 32'd0);
    chk("run_first_addr", imem_addr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("seq_instr", instr_out, img[k]);
      chk("seq_pc", pc_out, 32'(k));
      chk("seq_valid", 32'(instr_valid), 32'd1);
    end
    tick();
    chk("zero_halt", 32'(halted), 32'd1);
    chk("zero_fault", 32'(fault), 32'd0);
    chk("zero_valid", 32'(instr_valid), 32'd0);
    chk("zero_instr_hold", instr_out, 32'h30000033);
    chk("zero_pc_hold", imem_addr, 32'd4);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("done_in_halt", 32'(halted), 32'd1);

    // Stall then branch-under-stall.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("reload_ready", 32'(load_ready), 32'd1);
    chk("reload_count", 32'(load_count), 32'd0);
    write_word(7'd8, 32'h80000088, 1'b1);
    tick();
    tick();
    chk("pre_stall_instr", instr_out, 32'h10000011);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_instr", instr_out, 32'h10000011);
      chk("stall_pc_out", pc_out, 32'd1);
      chk("stall_pc", imem_addr, 32'd2);
    end
    stall = 1'b0;
    tick();
    chk("resume_instr", instr_out, 32'h20000022);
    chk("resume_pc_out", pc_out, 32'd2);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd8;
    tick();
    stall = 1'b0; branch_taken = 1'b0;
    chk("br_squash", 32'(instr_valid), 32'd0);
    chk("br_addr", imem_addr, 32'd8);
    tick();
    chk("br_instr", instr_out, 32'h80000088);
    chk("br_pc_out", pc_out, 32'd8);
    chk("br_valid", 32'(instr_valid), 32'd1);
    tick();
    chk("br_then_halt", 32'(halted), 32'd1);

    // Out-of-range branch.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    branch_taken = 1'b1; branch_target = 32'd200;
    tick();
    branch_taken = 1'b0;
    chk("oor_halt", 32'(halted), 32'd1);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_valid", 32'(instr_valid), 32'd0);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("oor_reload_halt", 32'(halted), 32'd0);
    chk("oor_reload_fault", 32'(fault), 32'd0);
    chk("oor_reload_ready", 32'(load_ready), 32'd1);

    // Full image, run off the end.
    for (int i = 0; i < 128; i++) write_word(7'(i), 32'hC0000000 + 32'(i), 1'b0);
    write_word(7'd0, 32'hC0000000, 1'b0);
    chk("count_sat", 32'(load_count), 32'd128);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    ndeliv = 0; nbad = 0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      if (instr_valid) begin
        if (instr_out != 32'hC0000000 + pc_out) nbad++;
        if (pc_out != 32'(ndeliv)) nbad++;
        ndeliv++;
      end
      if (halted) done = 1'b1;
    end
    chk("end_reached", 32'(done), 32'd1);
    chk("end_deliv", 32'(ndeliv), 32'd128);
    chk("end_stream_ok", 32'(nbad), 32'd0);
    chk("end_pc_out", pc_out, 32'd127);
    chk("end_instr", instr_out, 32'hC000007F);
    chk("end_valid", 32'(instr_valid), 32'd1);
    chk("end_fault", 32'(fault), 32'd1);
    tick();
    chk("end_valid_drop", 32'(instr_valid), 32'd0);
    chk("end_no_wrap", imem_addr, 32'd127);
    chk("end_pc_hold", pc_out, 32'd127);

    // Reset in the middle of BOOT.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    write_word(7'd20, 32'h55555555, 1'b0);
    write_word(7'd21, 32'h66666666, 1'b0);
    write_word(7'd22, 32'h00000000, 1'b0);
    chk("mid_count", 32'(load_count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(load_count), 32'd0);
    chk("mid_rst_ready", 32'(load_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    branch_taken = 1'b1; branch_target = 32'd20;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("retain_w20", instr_out, 32'h55555555);
    chk("retain_pc20", pc_out, 32'd20);
    tick();
    chk("retain_w21", instr_out, 32'h66666666);
    tick();
    chk("retain_halt", 32'(halted), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
